credit_sender: RTL and testbench

Sender-side half of a credit-based latency-insensitive channel. It sits directly upstream of `credit_fifo` and tracks how many free slots remain in the downstream FIFO. It accepts words from the producer with a valid/ready handshake and forwards them to the FIFO as registered enqueue pulses. It restores credit whenever the FIFO's consumer dequeues, so the FIFO can never overflow and its `full` output stays unused.

---
 rtl/credit_sender.sv | 96 +++++++++
 tb/tb_credit_sender.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// Sender half of a credit-based channel: accepts producer words while credits
// remain, forwards them as registered enqueue pulses, and restores credit on dequeue.
module credit_sender #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_ADDR    = 2,
    parameter int CREDIT_DELAY = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_enq,
    input  logic                         i_credit,
    output logic [FIFO_ADDR:0]           o_credits,
    output logic                         o_credit_err
);

    localparam int            CW          = FIFO_ADDR + 1;
    localparam logic [CW-1:0] MAX_CREDITS = CW'(2 ** FIFO_ADDR);

    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         enq_q, enq_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         err_q, err_d;
    logic                         credit_dly;
    logic                         fire;

    // Credit-return delay line models the wire latency back from the consumer.
    generate
        if (CREDIT_DELAY == 0) begin : g_no_dly
            assign credit_dly = i_credit;
        end else begin : g_dly
            logic [CREDIT_DELAY-1:0] dly_q, dly_d;

            always_comb begin
                dly_d    = dly_q;
                dly_d[0] = i_credit;
                for (int i = 1; i < CREDIT_DELAY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign credit_dly = dly_q[CREDIT_DELAY-1];
        end
    endgenerate

    assign o_ready = (cnt_q != '0);
    assign fire    = i_valid & o_ready;

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        enq_d  = fire;
        data_d = fire ? i_data : data_q;
        if (fire && !credit_dly) begin
            cnt_d = cnt_q - CW'(1);
        end else if (credit_dly && !fire) begin
            // A credit with nothing outstanding means the return path is broken.
            if (cnt_q == MAX_CREDITS) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= MAX_CREDITS;
            enq_q  <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            enq_q  <= enq_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign o_enq        = enq_q;
    assign o_data       = data_q;
    assign o_credits    = cnt_q;
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: directed credit scenarios plus an end-to-end run
// against a behavioural 4-entry FIFO whose dequeues return credits.
module tb_credit_sender;

    logic               clock = 1'b0;
    logic               reset;
    logic signed [15:0] i_data;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] o_data;
    logic               o_enq;
    logic               i_credit;
    logic [2:0]         o_credits;
    logic               o_credit_err;

    credit_sender dut (
        .clock        (clock),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_enq        (o_enq),
        .i_credit     (i_credit),
        .o_credits    (o_credits),
        .o_credit_err (o_credit_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int enq_seen = 0;
    logic signed [15:0] exp_q[$];
    logic signed [15:0] fifo_q[$];
    bit e2e = 1'b0;
    int e2e_rx = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Stimulus side: every accepted word becomes an expected enqueue.
    always @(posedge clock) begin
        if (!reset && i_valid && o_ready) exp_q.push_back(i_data);
    end

    // Monitor: each enqueue pulse must carry the oldest accepted word.
    always @(negedge clock) begin
        if (!reset && o_enq) begin
            enq_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_enq", 1, 0);
            end else begin
                check("enq_data", int'(o_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Behavioural downstream FIFO; i_credit doubles as its dequeue strobe.
    always @(posedge clock) begin
        if (e2e) begin
            if (i_credit) begin
                if (fifo_q.size() == 0) begin
                    check("fifo_underflow", 1, 0);
                end else begin
                    check("fifo_order", int'(fifo_q.pop_front()), int'(16'(e2e_rx)));
                    e2e_rx++;
                end
            end
            if (o_enq) begin
                fifo_q.push_back(o_data);
                check("fifo_no_overflow", int'(fifo_q.size() <= 4), 1);
            end
        end
    end

    initial begin
        bit rdy;
        bit acc;
        int next_send;
        int guard;
        localparam int N_WORDS = 2000;

        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_credit = 1'b0;
        repeat (3) next();
        reset = 1'b0;
        @(negedge clock);
        check("rst_enq", o_enq, 0);
        check("rst_data", int'(o_data), 0);
        check("rst_credits", o_credits, 4);
        check("rst_ready", o_ready, 1);
        check("rst_err", o_credit_err, 0);

        // Exhaustion: words 1..5 offered, only 4 credits.
        next();
        i_valid = 1'b1; i_data = 16'sd1;
        repeat (6) begin
            @(negedge clock);
            rdy = o_ready;
            next();
            if (rdy && i_data < 16'sd5) i_data = i_data + 16'sd1;
        end
        @(negedge clock);
        check("exh_credits", o_credits, 0);
        check("exh_ready", o_ready, 0);
        check("exh_enq_count", enq_seen, 4);
        check("exh_exp_empty", exp_q.size(), 0);

        // One credit returned in cycle N reopens the channel in N+2.
        next();
        i_credit = 1'b1;
        @(negedge clock); check("res_ready_n", o_ready, 0);
        next();
        i_credit = 1'b0;
        @(negedge clock); check("res_ready_n1", o_ready, 0);
        next();
        @(negedge clock);
        check("res_ready_n2", o_ready, 1);
        check("res_credits_n2", o_credits, 1);
        next();
        i_valid = 1'b0;
        @(negedge clock);
        check("res_enq_n3", o_enq, 1);
        check("res_data_n3", int'(o_data), 5);
        check("res_credits_n3", o_credits, 0);

        // Build up to 2 credits, then fire in the cycle a delayed credit lands.
        next(); i_credit = 1'b1;
        next(); i_credit = 1'b1;
        next(); i_credit = 1'b0;
        next();
        @(negedge clock); check("sim_pre_credits", o_credits, 2);
        i_credit = 1'b1;
        next();
        i_credit = 1'b0; i_valid = 1'b1; i_data = 16'sd6;
        next();
        i_valid = 1'b0;
        @(negedge clock);
        check("sim_credits", o_credits, 2);
        check("sim_enq", o_enq, 1);
        next();
        @(negedge clock);
        check("sim_enq_once", o_enq, 0);
        check("sim_credits_hold", o_credits, 2);

        // Restore to full, then a spurious credit must set the sticky error.
        i_credit = 1'b1;
        next(); next();
        i_credit = 1'b0;
        next(); next();
        @(negedge clock);
        check("full_credits", o_credits, 4);
        check("full_err", o_credit_err, 0);
        i_credit = 1'b1;
        next();
        i_credit = 1'b0;
        next();
        @(negedge clock);
        check("err_set", o_credit_err, 1);
        check("err_credits_sat", o_credits, 4);
        repeat (3) next();
        @(negedge clock);
        check("err_sticky", o_credit_err, 1);

        // Reset while a credit sits in the delay line drops that credit.
        i_valid = 1'b1; i_data = 16'sd7;
        next();
        i_valid = 1'b0; i_credit = 1'b1;
        next();
        i_credit = 1'b0; reset = 1'b1;
        next();
        reset = 1'b0;
        @(negedge clock);
        check("rdl_credits", o_credits, 4);
        check("rdl_err", o_credit_err, 0);
        next();
        @(negedge clock);
        check("rdl_err_after", o_credit_err, 0);
        check("rdl_credits_after", o_credits, 4);

        // End-to-end with random producer and consumer.
        next();
        e2e = 1'b1;
        next_send = 0;
        i_data = '0;
        guard = 0;
        while ((next_send < N_WORDS || fifo_q.size() != 0 || i_valid) && guard < 50000) begin
            @(negedge clock);
            acc = i_valid && o_ready;
            next();
            guard++;
            if (acc) next_send++;
            i_valid  = (next_send < N_WORDS) && ($urandom_range(0, 3) != 0);
            i_data   = 16'(next_send);
            i_credit = (fifo_q.size() != 0) && ($urandom_range(0, 2) != 0);
        end
        check("e2e_no_timeout", int'(guard < 50000), 1);
        i_credit = 1'b0;
        repeat (4) next();
        @(negedge clock);
        check("e2e_rx_count", e2e_rx, N_WORDS);
        check("e2e_credits", o_credits, 4);
        check("e2e_err", o_credit_err, 0);
        check("e2e_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
